iiitb_vm_multi: RTL and testbench

- Parametrised multi-product vending controller with an accumulated credit register.
- Supports configurable coin values and per-product prices, per-product stock inhibit, and cancel/refund.
- Returns change as a sequence of coins, one per handshake.
- Sits behind user_proj_example: coin, select and cancel inputs come from io_in or la_data_in; vend and change outputs drive io_out.

---
 rtl/iiitb_vm_pkg.sv | 31 +++
 rtl/iiitb_vm_change_sel.sv | 39 +++
 rtl/iiitb_vm_multi.sv | 168 ++++++++++++++++
 tb/tb_iiitb_vm_multi.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/iiitb_vm_pkg.sv
// Shared types and helpers for the multi-product vending controller.
// Holds the FSM state encoding, the coin codes and the coin-value lookup.
package iiitb_vm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } vm_state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_1    = 2'b01;
    localparam logic [1:0] COIN_2    = 2'b10;
    localparam logic [1:0] COIN_3    = 2'b11;

    function automatic int unsigned coin_value(
        input logic [1:0]  code,
        input int unsigned cv1,
        input int unsigned cv2,
        input int unsigned cv3
    );
        case (code)
            COIN_1:  return cv1;
            COIN_2:  return cv2;
            COIN_3:  return cv3;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/iiitb_vm_change_sel.sv
// Greedy change selector: picks the largest coin whose value fits in the
// given credit, returning its code and value (COIN_NONE / 0 when credit is 0).
module iiitb_vm_change_sel
    import iiitb_vm_pkg::*;
#(
    parameter int          CREDIT_W = 8,
    parameter int unsigned CV1      = 1,
    parameter int unsigned CV2      = 2,
    parameter int unsigned CV3      = 5
) (
    input  logic [CREDIT_W-1:0] credit,
    output logic [1:0]          code,
    output logic [CREDIT_W-1:0] value
);

    localparam int CW1 = CREDIT_W + 1;
    localparam logic [CW1-1:0] V1 = CW1'(CV1);
    localparam logic [CW1-1:0] V2 = CW1'(CV2);
    localparam logic [CW1-1:0] V3 = CW1'(CV3);

    logic [CW1-1:0] credit_ext;
    assign credit_ext = {1'b0, credit};

    always_comb begin
        code  = COIN_NONE;
        value = '0;
        if (credit_ext >= V3) begin
            code  = COIN_3;
            value = CREDIT_W'(CV3);
        end else if (credit_ext >= V2) begin
            code  = COIN_2;
            value = CREDIT_W'(CV2);
        end else if (credit_ext >= V1) begin
            code  = COIN_1;
            value = CREDIT_W'(CV1);
        end
    end

endmodule

// File: rtl/iiitb_vm_multi.sv
// Multi-product vending controller: accumulates coin credit, vends a selected
// product when affordable and in stock, and pays change back one coin per handshake.
module iiitb_vm_multi
    import iiitb_vm_pkg::*;
#(
    parameter int          N_PROD      = 4,
    parameter int          CREDIT_W    = 8,
    parameter int          PRICE_W     = 8,
    parameter logic [N_PROD*PRICE_W-1:0] PRICE_TABLE = {8'd15, 8'd10, 8'd7, 8'd5},
    parameter int unsigned CV1         = 1,
    parameter int unsigned CV2         = 2,
    parameter int unsigned CV3         = 5,
    localparam int         SEL_W       = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                coin_valid,
    input  logic [1:0]          coin_in,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel,
    input  logic                cancel,
    input  logic [N_PROD-1:0]   stock_empty,
    input  logic                change_ready,
    output logic                vend_o,
    output logic [SEL_W-1:0]    vend_id,
    output logic                change_valid,
    output logic [1:0]          change_coin,
    output logic                coin_reject,
    output logic                sel_reject,
    output logic [CREDIT_W-1:0] credit_o,
    output logic                busy
);

    localparam int CW1   = CREDIT_W + 1;
    localparam int CMP_W = (PRICE_W > CREDIT_W) ? PRICE_W + 1 : CREDIT_W + 1;

    vm_state_t           state_reg, state_next;
    logic [CREDIT_W-1:0] credit_reg, credit_next;
    logic [CREDIT_W-1:0] pay_value_reg;
    logic                vend_reg, change_valid_reg, coin_reject_reg, sel_reject_reg, busy_reg;
    logic [SEL_W-1:0]    vend_id_reg;
    logic [1:0]          change_coin_reg;

    logic                coin_rej_next, sel_rej_next;
    logic [1:0]          next_code;
    logic [CREDIT_W-1:0] next_value;

    logic [PRICE_W-1:0] price_arr [N_PROD];

    genvar gi;
    generate
        for (gi = 0; gi < N_PROD; gi++) begin : g_price
            assign price_arr[gi] = PRICE_TABLE[gi*PRICE_W +: PRICE_W];
        end
    endgenerate

    // An index with no matching product reads as out of stock, so it is refused.
    logic [PRICE_W-1:0] price_sel;
    logic               stock_sel;
    always_comb begin
        price_sel = '0;
        stock_sel = 1'b1;
        for (int i = 0; i < N_PROD; i++) begin
            if (32'(sel) == i) begin
                price_sel = price_arr[i];
                stock_sel = stock_empty[i];
            end
        end
    end

    logic           sel_ok;
    logic           coin_present;
    logic [CW1-1:0] credit_sum;

    assign sel_ok       = !stock_sel && (CMP_W'(price_sel) <= CMP_W'(credit_reg));
    assign coin_present = coin_valid && (coin_in != COIN_NONE);
    assign credit_sum   = {1'b0, credit_reg} + CW1'(coin_value(coin_in, CV1, CV2, CV3));

    always_comb begin
        state_next    = state_reg;
        credit_next   = credit_reg;
        coin_rej_next = 1'b0;
        sel_rej_next  = 1'b0;
        case (state_reg)
            IDLE, CREDIT: begin
                if (cancel) begin
                    coin_rej_next = coin_present;
                    if (credit_reg != '0) state_next = CHANGE;
                end else if (sel_valid) begin
                    coin_rej_next = coin_present;
                    if (sel_ok) begin
                        credit_next = credit_reg - CREDIT_W'(price_sel);
                        state_next  = VEND;
                    end else begin
                        sel_rej_next = 1'b1;
                    end
                end else if (coin_present) begin
                    if (credit_sum[CREDIT_W]) begin
                        coin_rej_next = 1'b1;
                    end else begin
                        credit_next = credit_sum[CREDIT_W-1:0];
                        state_next  = (credit_next != '0) ? CREDIT : IDLE;
                    end
                end
            end
            VEND: begin
                coin_rej_next = coin_present;
                state_next    = (credit_reg != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                coin_rej_next = coin_present;
                if (change_valid_reg && change_ready) begin
                    credit_next = credit_reg - pay_value_reg;
                    if (credit_next == '0) state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The coin offered next cycle is chosen from the credit that will remain.
    iiitb_vm_change_sel #(
        .CREDIT_W (CREDIT_W),
        .CV1      (CV1),
        .CV2      (CV2),
        .CV3      (CV3)
    ) u_change_sel (
        .credit (credit_next),
        .code   (next_code),
        .value  (next_value)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg        <= IDLE;
            credit_reg       <= '0;
            pay_value_reg    <= '0;
            vend_reg         <= 1'b0;
            vend_id_reg      <= '0;
            change_valid_reg <= 1'b0;
            change_coin_reg  <= COIN_NONE;
            coin_reject_reg  <= 1'b0;
            sel_reject_reg   <= 1'b0;
            busy_reg         <= 1'b0;
        end else begin
            state_reg        <= state_next;
            credit_reg       <= credit_next;
            vend_reg         <= (state_next == VEND);
            vend_id_reg      <= (state_next == VEND) ? sel : '0;
            change_valid_reg <= (state_next == CHANGE);
            change_coin_reg  <= (state_next == CHANGE) ? next_code : COIN_NONE;
            pay_value_reg    <= (state_next == CHANGE) ? next_value : '0;
            coin_reject_reg  <= coin_rej_next;
            sel_reject_reg   <= sel_rej_next;
            busy_reg         <= (state_next == VEND) || (state_next == CHANGE);
        end
    end

    assign vend_o       = vend_reg;
    assign vend_id      = vend_id_reg;
    assign change_valid = change_valid_reg;
    assign change_coin  = change_coin_reg;
    assign coin_reject  = coin_reject_reg;
    assign sel_reject   = sel_reject_reg;
    assign credit_o     = credit_reg;
    assign busy         = busy_reg;

endmodule

// File: tb/tb_iiitb_vm_multi.sv
// Directed self-checking bench for iiitb_vm_multi: default instance plus a
// CREDIT_W=4 instance sharing the same stimulus for the credit-overflow case.
module tb_iiitb_vm_multi;

    logic       clock = 1'b0;
    logic       reset;
    logic       coin_valid;
    logic [1:0] coin_in;
    logic       sel_valid;
    logic [1:0] sel;
    logic       cancel;
    logic [3:0] stock_empty;
    logic       change_ready;

    logic       vend_o, change_valid, coin_reject, sel_reject, busy;
    logic [1:0] vend_id, change_coin;
    logic [7:0] credit_o;

    logic       vend_o4, change_valid4, coin_reject4, sel_reject4, busy4;
    logic [1:0] vend_id4, change_coin4;
    logic [3:0] credit_o4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    iiitb_vm_multi dut (
        .clock        (clock),
        .reset        (reset),
        .coin_valid   (coin_valid),
        .coin_in      (coin_in),
        .sel_valid    (sel_valid),
        .sel          (sel),
        .cancel       (cancel),
        .stock_empty  (stock_empty),
        .change_ready (change_ready),
        .vend_o       (vend_o),
        .vend_id      (vend_id),
        .change_valid (change_valid),
        .change_coin  (change_coin),
        .coin_reject  (coin_reject),
        .sel_reject   (sel_reject),
        .credit_o     (credit_o),
        .busy         (busy)
    );

    iiitb_vm_multi #(.CREDIT_W(4)) dut4 (
        .clock        (clock),
        .reset        (reset),
        .coin_valid   (coin_valid),
        .coin_in      (coin_in),
        .sel_valid    (sel_valid),
        .sel          (sel),
        .cancel       (cancel),
        .stock_empty  (stock_empty),
        .change_ready (change_ready),
        .vend_o       (vend_o4),
        .vend_id      (vend_id4),
        .change_valid (change_valid4),
        .change_coin  (change_coin4),
        .coin_reject  (coin_reject4),
        .sel_reject   (sel_reject4),
        .credit_o     (credit_o4),
        .busy         (busy4)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic put_coin(input logic [1:0] code);
        coin_valid = 1'b1;
        coin_in    = code;
        tick();
        coin_valid = 1'b0;
        coin_in    = 2'b00;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_vend"},    32'(vend_o),       32'd0);
        chk({tag, "_vid"},     32'(vend_id),      32'd0);
        chk({tag, "_cvalid"},  32'(change_valid), 32'd0);
        chk({tag, "_ccoin"},   32'(change_coin),  32'd0);
        chk({tag, "_crej"},    32'(coin_reject),  32'd0);
        chk({tag, "_srej"},    32'(sel_reject),   32'd0);
        chk({tag, "_credit"},  32'(credit_o),     32'd0);
        chk({tag, "_busy"},    32'(busy),         32'd0);
    endtask

    initial begin
        reset        = 1'b1;
        coin_valid   = 1'b0;
        coin_in      = 2'b00;
        sel_valid    = 1'b0;
        sel          = 2'd0;
        cancel       = 1'b0;
        stock_empty  = 4'b0000;
        change_ready = 1'b0;
        tick();
        tick();
        chk_all_zero("rst");
        chk("rst_credit4", 32'(credit_o4), 32'd0);
        reset = 1'b0;
        $display("step: reset state checked");

        // Two 5-coins, buy product 1 (price 7), change 3 = 2 + 1.
        put_coin(2'b11);
        chk("a_credit5", 32'(credit_o), 32'd5);
        put_coin(2'b11);
        chk("a_credit10", 32'(credit_o), 32'd10);
        sel_valid = 1'b1; sel = 2'd1; change_ready = 1'b1;
        tick();
        sel_valid = 1'b0;
        chk("a_vend", 32'(vend_o), 32'd1);
        chk("a_vend_id", 32'(vend_id), 32'd1);
        chk("a_credit3", 32'(credit_o), 32'd3);
        chk("a_busy_vend", 32'(busy), 32'd1);
        chk("a_cvalid_vend", 32'(change_valid), 32'd0);
        tick();
        chk("a_vend_drop", 32'(vend_o), 32'd0);
        chk("a_cvalid1", 32'(change_valid), 32'd1);
        chk("a_coin10", 32'(change_coin), 32'd2);
        tick();
        chk("a_coin01", 32'(change_coin), 32'd1);
        chk("a_credit1", 32'(credit_o), 32'd1);
        tick();
        chk("a_cvalid_end", 32'(change_valid), 32'd0);
        chk("a_credit0", 32'(credit_o), 32'd0);
        chk("a_busy_end", 32'(busy), 32'd0);
        $display("step: vend product 1 with change checked");

        // Credit 2, product 3 costs 15 -> refused.
        put_coin(2'b10);
        sel_valid = 1'b1; sel = 2'd3;
        tick();
        sel_valid = 1'b0;
        chk("b_srej", 32'(sel_reject), 32'd1);
        chk("b_credit2", 32'(credit_o), 32'd2);
        chk("b_novend", 32'(vend_o), 32'd0);
        tick();
        chk("b_srej_pulse", 32'(sel_reject), 32'd0);
        chk("b_novend2", 32'(vend_o), 32'd0);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("b_refund_coin", 32'(change_coin), 32'd2);
        tick();
        chk("b_refund_done", 32'(change_valid), 32'd0);
        chk("b_credit0", 32'(credit_o), 32'd0);
        $display("step: unaffordable selection checked");

        // Credit 8, cancel with change_ready low for 3 cycles.
        put_coin(2'b11);
        put_coin(2'b10);
        put_coin(2'b01);
        chk("c_credit8", 32'(credit_o), 32'd8);
        change_ready = 1'b0;
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("c_hold_valid", 32'(change_valid), 32'd1);
            chk("c_hold_coin", 32'(change_coin), 32'd3);
            chk("c_hold_credit", 32'(credit_o), 32'd8);
            tick();
        end
        change_ready = 1'b1;
        tick();
        chk("c_credit3", 32'(credit_o), 32'd3);
        chk("c_coin10", 32'(change_coin), 32'd2);
        tick();
        chk("c_credit1", 32'(credit_o), 32'd1);
        chk("c_coin01", 32'(change_coin), 32'd1);
        tick();
        chk("c_credit0", 32'(credit_o), 32'd0);
        chk("c_cvalid_end", 32'(change_valid), 32'd0);
        chk("c_busy_end", 32'(busy), 32'd0);
        $display("step: cancel refund with backpressure checked");

        // Credit 14 in a 4-bit credit register, a 5-coin would overflow.
        put_coin(2'b11);
        put_coin(2'b11);
        put_coin(2'b10);
        put_coin(2'b10);
        chk("d_credit14_w4", 32'(credit_o4), 32'd14);
        put_coin(2'b11);
        chk("d_crej_w4", 32'(coin_reject4), 32'd1);
        chk("d_credit_w4", 32'(credit_o4), 32'd14);
        chk("d_crej_w8", 32'(coin_reject), 32'd0);
        chk("d_credit19_w8", 32'(credit_o), 32'd19);
        tick();
        chk("d_crej_pulse_w4", 32'(coin_reject4), 32'd0);
        $display("step: credit overflow on 4-bit instance checked");

        // Reset for two cycles while paying out credit 3.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        put_coin(2'b10);
        put_coin(2'b01);
        change_ready = 1'b0;
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("e_change_valid", 32'(change_valid), 32'd1);
        chk("e_change_coin", 32'(change_coin), 32'd2);
        chk("e_credit3", 32'(credit_o), 32'd3);
        reset = 1'b1;
        tick();
        chk_all_zero("e_rst1");
        tick();
        chk_all_zero("e_rst2");
        reset = 1'b0;
        change_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("e_no_revalid", 32'(change_valid), 32'd0);
            chk("e_credit_idle", 32'(credit_o), 32'd0);
        end
        $display("step: reset during change checked");

        // Out-of-stock product 0 with enough credit.
        put_coin(2'b11);
        stock_empty = 4'b0001;
        sel_valid = 1'b1; sel = 2'd0;
        tick();
        sel_valid = 1'b0;
        stock_empty = 4'b0000;
        chk("f_srej_stock", 32'(sel_reject), 32'd1);
        chk("f_credit5", 32'(credit_o), 32'd5);
        chk("f_novend", 32'(vend_o), 32'd0);
        $display("step: stock inhibit checked");

        // Cancel + select + coin in one cycle: cancel wins, coin rejected.
        put_coin(2'b10);
        chk("g_credit7", 32'(credit_o), 32'd7);
        cancel = 1'b1; sel_valid = 1'b1; sel = 2'd0;
        coin_valid = 1'b1; coin_in = 2'b01;
        tick();
        cancel = 1'b0; sel_valid = 1'b0; coin_valid = 1'b0; coin_in = 2'b00;
        chk("g_crej", 32'(coin_reject), 32'd1);
        chk("g_srej", 32'(sel_reject), 32'd0);
        chk("g_novend", 32'(vend_o), 32'd0);
        chk("g_cvalid", 32'(change_valid), 32'd1);
        chk("g_coin11", 32'(change_coin), 32'd3);
        chk("g_credit7_hold", 32'(credit_o), 32'd7);
        tick();
        chk("g_credit2", 32'(credit_o), 32'd2);
        chk("g_coin10", 32'(change_coin), 32'd2);
        chk("g_crej_pulse", 32'(coin_reject), 32'd0);
        tick();
        chk("g_credit0", 32'(credit_o), 32'd0);
        chk("g_cvalid_end", 32'(change_valid), 32'd0);
        $display("step: cancel priority checked");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
